// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: op-code encoding and size defaults.
// Op codes follow the dispatch encoding; OP_NONE marks an idle EX cycle.
package alu_rs_pkg;

    localparam int RS_SIZE_DEF   = 16;
    localparam int ROB_WIDTH_DEF = 4;
    localparam int ORDER_W       = 6;

    typedef enum logic [ORDER_W-1:0] {
        OP_NONE  = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_LB    = 6'd11,
        OP_LH    = 6'd12,
        OP_LW    = 6'd13,
        OP_LBU   = 6'd14,
        OP_LHU   = 6'd15,
        OP_SB    = 6'd16,
        OP_SH    = 6'd17,
        OP_SW    = 6'd18,
        OP_ADDI  = 6'd19,
        OP_SLTI  = 6'd20,
        OP_SLTIU = 6'd21,
        OP_XORI  = 6'd22,
        OP_ORI   = 6'd23,
        OP_ANDI  = 6'd24,
        OP_SLLI  = 6'd25,
        OP_SRLI  = 6'd26,
        OP_SRAI  = 6'd27,
        OP_ADD   = 6'd28,
        OP_SUB   = 6'd29,
        OP_SLL   = 6'd30,
        OP_SLT   = 6'd31,
        OP_SLTU  = 6'd32,
        OP_XOR   = 6'd33,
        OP_SRL   = 6'd34,
        OP_SRA   = 6'd35,
        OP_OR    = 6'd36,
        OP_AND   = 6'd37
    } op_e;

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder over an N-bit request vector, with a found flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the result.
module alu_rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the EX ALU: holds dispatched ops until operands arrive on the CDBs.
// Latency: one cycle from an entry becoming ready (registered state) to its result on out_*.
// Backpressure: rdy_in low freezes everything; full asserts with one slot of headroom.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,

    input  logic                 in_valid,
    input  logic [5:0]           in_order,
    input  logic [31:0]          in_vj,
    input  logic [31:0]          in_vk,
    input  logic                 in_qj_busy,
    input  logic                 in_qk_busy,
    input  logic [ROB_WIDTH-1:0] in_qj,
    input  logic [ROB_WIDTH-1:0] in_qk,
    input  logic [31:0]          in_A,
    input  logic [31:0]          in_pc,
    input  logic [ROB_WIDTH-1:0] in_rob,
    output logic                 full,

    input  logic                 alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob,
    input  logic [31:0]          lsb_cdb_value,

    output logic [5:0]           ex_order,
    output logic [31:0]          ex_vj,
    output logic [31:0]          ex_vk,
    output logic [31:0]          ex_A,
    output logic [31:0]          ex_pc,
    input  logic [31:0]          ex_value,
    input  logic [31:0]          ex_topc,

    output logic                 out_valid,
    output logic [ROB_WIDTH-1:0] out_rob,
    output logic [31:0]          out_value,
    output logic [31:0]          out_topc
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0]   qk_busy_q, qk_busy_d;
    logic [5:0]           order_q [RS_SIZE];
    logic [5:0]           order_d [RS_SIZE];
    logic [31:0]          vj_q    [RS_SIZE];
    logic [31:0]          vj_d    [RS_SIZE];
    logic [31:0]          vk_q    [RS_SIZE];
    logic [31:0]          vk_d    [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q    [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_d    [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q    [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_d    [RS_SIZE];
    logic [31:0]          a_q     [RS_SIZE];
    logic [31:0]          a_d     [RS_SIZE];
    logic [31:0]          pc_q    [RS_SIZE];
    logic [31:0]          pc_d    [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_d   [RS_SIZE];

    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 out_valid_q, out_valid_d;
    logic [ROB_WIDTH-1:0] out_rob_q, out_rob_d;
    logic [31:0]          out_value_q, out_value_d;
    logic [31:0]          out_topc_q, out_topc_d;

    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_SIZE-1:0]   free_vec;
    logic [IDX_W-1:0]     ready_idx, free_idx;
    logic                 ready_found, free_found;

    logic [31:0]          disp_vj, disp_vk;
    logic                 disp_qj_busy, disp_qk_busy;
    logic                 dispatch_en, issue_en;

    assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;
    assign free_vec  = ~busy_q;

    alu_rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    alu_rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
        .vec   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    always_comb begin
        ex_order = OP_NONE;
        ex_vj    = 32'd0;
        ex_vk    = 32'd0;
        ex_A     = 32'd0;
        ex_pc    = 32'd0;
        if (ready_found) begin
            ex_order = order_q[ready_idx];
            ex_vj    = vj_q[ready_idx];
            ex_vk    = vk_q[ready_idx];
            ex_A     = a_q[ready_idx];
            ex_pc    = pc_q[ready_idx];
        end
    end

    // A dispatching op may name a producer that is broadcasting right now.
    always_comb begin
        disp_vj      = in_vj;
        disp_qj_busy = in_qj_busy;
        if (in_qj_busy && alu_cdb_valid && (in_qj == alu_cdb_rob)) begin
            disp_vj      = alu_cdb_value;
            disp_qj_busy = 1'b0;
        end else if (in_qj_busy && lsb_cdb_valid && (in_qj == lsb_cdb_rob)) begin
            disp_vj      = lsb_cdb_value;
            disp_qj_busy = 1'b0;
        end
        disp_vk      = in_vk;
        disp_qk_busy = in_qk_busy;
        if (in_qk_busy && alu_cdb_valid && (in_qk == alu_cdb_rob)) begin
            disp_vk      = alu_cdb_value;
            disp_qk_busy = 1'b0;
        end else if (in_qk_busy && lsb_cdb_valid && (in_qk == lsb_cdb_rob)) begin
            disp_vk      = lsb_cdb_value;
            disp_qk_busy = 1'b0;
        end
    end

    assign dispatch_en = rdy_in && !clear && in_valid && free_found;
    assign issue_en    = rdy_in && !clear && ready_found;

    always_comb begin
        busy_d      = busy_q;
        qj_busy_d   = qj_busy_q;
        qk_busy_d   = qk_busy_q;
        order_d     = order_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        a_d         = a_q;
        pc_d        = pc_q;
        rob_d       = rob_q;
        count_d     = count_q;
        full_d      = full_q;
        out_valid_d = 1'b0;
        out_rob_d   = out_rob_q;
        out_value_d = out_value_q;
        out_topc_d  = out_topc_q;

        if (clear) begin
            busy_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (alu_cdb_valid && (qj_q[i] == alu_cdb_rob)) begin
                        vj_d[i]      = alu_cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end else if (lsb_cdb_valid && (qj_q[i] == lsb_cdb_rob)) begin
                        vj_d[i]      = lsb_cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (alu_cdb_valid && (qk_q[i] == alu_cdb_rob)) begin
                        vk_d[i]      = alu_cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end else if (lsb_cdb_valid && (qk_q[i] == lsb_cdb_rob)) begin
                        vk_d[i]      = lsb_cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end

            if (issue_en) begin
                busy_d[ready_idx] = 1'b0;
                out_valid_d       = 1'b1;
                out_rob_d         = rob_q[ready_idx];
                out_value_d       = ex_value;
                out_topc_d        = ex_topc;
            end

            // The free slot is never the issuing slot, so both can land together.
            if (dispatch_en) begin
                busy_d[free_idx]    = 1'b1;
                order_d[free_idx]   = in_order;
                vj_d[free_idx]      = disp_vj;
                vk_d[free_idx]      = disp_vk;
                qj_busy_d[free_idx] = disp_qj_busy;
                qk_busy_d[free_idx] = disp_qk_busy;
                qj_d[free_idx]      = in_qj;
                qk_d[free_idx]      = in_qk;
                a_d[free_idx]       = in_A;
                pc_d[free_idx]      = in_pc;
                rob_d[free_idx]     = in_rob;
            end

            count_d = count_q + CNT_W'(dispatch_en) - CNT_W'(issue_en);
            full_d  = (count_d >= CNT_W'(RS_SIZE - 1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            qj_busy_q   <= '0;
            qk_busy_q   <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_rob_q   <= '0;
            out_value_q <= 32'd0;
            out_topc_q  <= 32'd0;
            for (int i = 0; i < RS_SIZE; i++) begin
                order_q[i] <= OP_NONE;
                vj_q[i]    <= 32'd0;
                vk_q[i]    <= 32'd0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                a_q[i]     <= 32'd0;
                pc_q[i]    <= 32'd0;
                rob_q[i]   <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            qj_busy_q   <= qj_busy_d;
            qk_busy_q   <= qk_busy_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_rob_q   <= out_rob_d;
            out_value_q <= out_value_d;
            out_topc_q  <= out_topc_d;
            order_q     <= order_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            a_q         <= a_d;
            pc_q        <= pc_d;
            rob_q       <= rob_d;
        end
    end

    assign full      = full_q;
    assign out_valid = out_valid_q;
    assign out_rob   = out_rob_q;
    assign out_value = out_value_q;
    assign out_topc  = out_topc_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed table, multi-cycle corner sequences, then random traffic
// checked every cycle against a slot-array reference model of the station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_order = 6'd0;
    logic [31:0] in_vj = 32'd0, in_vk = 32'd0, in_A = 32'd0, in_pc = 32'd0;
    logic        in_qj_busy = 1'b0, in_qk_busy = 1'b0;
    logic [3:0]  in_qj = 4'd0, in_qk = 4'd0, in_rob = 4'd0;
    logic        full;
    logic        alu_cdb_valid, lsb_cdb_valid = 1'b0;
    logic [3:0]  alu_cdb_rob, lsb_cdb_rob = 4'd0;
    logic [31:0] alu_cdb_value, lsb_cdb_value = 32'd0;
    logic [5:0]  ex_order;
    logic [31:0] ex_vj, ex_vk, ex_A, ex_pc, ex_value, ex_topc;
    logic        out_valid;
    logic [3:0]  out_rob;
    logic [31:0] out_value, out_topc;

    // Extra ALU CDB source so a test can broadcast a tag of its choosing.
    logic        ext_alu_vld = 1'b0;
    logic [3:0]  ext_alu_rob = 4'd0;
    logic [31:0] ext_alu_value = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    function automatic logic [63:0] alu_ref(input logic [5:0] op, input logic [31:0] vj,
                                            input logic [31:0] vk, input logic [31:0] a,
                                            input logic [31:0] pc);
        logic [31:0] v;
        logic [31:0] t;
        v = 32'd0;
        t = pc + 32'd4;
        case (op)
            OP_LUI:   v = a;
            OP_AUIPC: v = pc + a;
            OP_JAL:   begin v = pc + 32'd4; t = pc + a; end
            OP_JALR:  begin v = pc + 32'd4; t = (vj + a) & ~32'd1; end
            OP_BEQ:   t = (vj == vk) ? pc + a : pc + 32'd4;
            OP_BNE:   t = (vj != vk) ? pc + a : pc + 32'd4;
            OP_BLT:   t = ($signed(vj) < $signed(vk)) ? pc + a : pc + 32'd4;
            OP_BLTU:  t = (vj < vk) ? pc + a : pc + 32'd4;
            OP_ADDI:  v = vj + a;
            OP_ADD:   v = vj + vk;
            OP_SUB:   v = vj - vk;
            OP_SLTU:  v = (vj < vk) ? 32'd1 : 32'd0;
            OP_XOR:   v = vj ^ vk;
            OP_OR:    v = vj | vk;
            OP_AND:   v = vj & vk;
            default:  ;
        endcase
        return {v, t};
    endfunction

    assign {ex_value, ex_topc} = alu_ref(ex_order, ex_vj, ex_vk, ex_A, ex_pc);
    assign alu_cdb_valid = ext_alu_vld | out_valid;
    assign alu_cdb_rob   = ext_alu_vld ? ext_alu_rob : out_rob;
    assign alu_cdb_value = ext_alu_vld ? ext_alu_value : out_value;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .in_valid(in_valid), .in_order(in_order), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy), .in_qj(in_qj), .in_qk(in_qk),
        .in_A(in_A), .in_pc(in_pc), .in_rob(in_rob), .full(full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_value(lsb_cdb_value),
        .ex_order(ex_order), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc),
        .ex_value(ex_value), .ex_topc(ex_topc),
        .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value), .out_topc(out_topc)
    );

    // Reference model: a plain array of slots plus the predicted CDB output.
    logic        m_busy [16];
    logic [5:0]  m_op   [16];
    logic [31:0] m_vj [16], m_vk [16], m_a [16], m_pc [16];
    logic        m_jw [16], m_kw [16];
    logic [3:0]  m_qj [16], m_qk [16], m_rob [16];
    logic        m_out_valid = 1'b0;
    logic [3:0]  m_out_rob = 4'd0;
    logic [31:0] m_out_value = 32'd0, m_out_topc = 32'd0;
    logic        m_full = 1'b0;

    task automatic model_edge();
        logic        av;
        logic [3:0]  ar;
        logic [31:0] aval;
        int          sel, fr, cnt;
        logic [63:0] res;
        av   = ext_alu_vld | m_out_valid;
        ar   = ext_alu_vld ? ext_alu_rob : m_out_rob;
        aval = ext_alu_vld ? ext_alu_value : m_out_value;
        if (rst_in) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            m_out_valid = 1'b0; m_out_rob = 4'd0; m_out_value = 32'd0; m_out_topc = 32'd0;
            m_full = 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            m_out_valid = 1'b0;
            m_full = 1'b0;
        end else if (!rdy_in) begin
            m_out_valid = 1'b0;
        end else begin
            sel = -1; fr = -1;
            for (int i = 0; i < 16; i++) begin
                if (sel < 0 && m_busy[i] && !m_jw[i] && !m_kw[i]) sel = i;
                if (fr < 0 && !m_busy[i]) fr = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_busy[i] && m_jw[i]) begin
                    if (av && m_qj[i] == ar) begin m_vj[i] = aval; m_jw[i] = 1'b0; end
                    else if (lsb_cdb_valid && m_qj[i] == lsb_cdb_rob) begin m_vj[i] = lsb_cdb_value; m_jw[i] = 1'b0; end
                end
                if (m_busy[i] && m_kw[i]) begin
                    if (av && m_qk[i] == ar) begin m_vk[i] = aval; m_kw[i] = 1'b0; end
                    else if (lsb_cdb_valid && m_qk[i] == lsb_cdb_rob) begin m_vk[i] = lsb_cdb_value; m_kw[i] = 1'b0; end
                end
            end
            m_out_valid = (sel >= 0);
            if (sel >= 0) begin
                res = alu_ref(m_op[sel], m_vj[sel], m_vk[sel], m_a[sel], m_pc[sel]);
                m_out_rob = m_rob[sel];
                m_out_value = res[63:32];
                m_out_topc = res[31:0];
                m_busy[sel] = 1'b0;
            end
            if (in_valid && fr >= 0) begin
                m_busy[fr] = 1'b1; m_op[fr] = in_order; m_a[fr] = in_A; m_pc[fr] = in_pc;
                m_rob[fr] = in_rob; m_qj[fr] = in_qj; m_qk[fr] = in_qk;
                m_vj[fr] = in_vj; m_jw[fr] = in_qj_busy;
                m_vk[fr] = in_vk; m_kw[fr] = in_qk_busy;
                if (in_qj_busy && av && in_qj == ar) begin m_vj[fr] = aval; m_jw[fr] = 1'b0; end
                else if (in_qj_busy && lsb_cdb_valid && in_qj == lsb_cdb_rob) begin m_vj[fr] = lsb_cdb_value; m_jw[fr] = 1'b0; end
                if (in_qk_busy && av && in_qk == ar) begin m_vk[fr] = aval; m_kw[fr] = 1'b0; end
                else if (in_qk_busy && lsb_cdb_valid && in_qk == lsb_cdb_rob) begin m_vk[fr] = lsb_cdb_value; m_kw[fr] = 1'b0; end
            end
            cnt = 0;
            for (int i = 0; i < 16; i++) if (m_busy[i]) cnt++;
            m_full = (cnt >= 15);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        check("model out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
        if (m_out_valid) begin
            check("model out_rob", {28'd0, out_rob}, {28'd0, m_out_rob});
            check("model out_value", out_value, m_out_value);
            check("model out_topc", out_topc, m_out_topc);
        end
        check("model full", {31'd0, full}, {31'd0, m_full});
    endtask

    task automatic set_op(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic jb, input logic [3:0] qj, input logic kb, input logic [3:0] qk,
                          input logic [31:0] a, input logic [31:0] pc, input logic [3:0] rob);
        in_valid = 1'b1; in_order = op; in_vj = vj; in_vk = vk;
        in_qj_busy = jb; in_qj = qj; in_qk_busy = kb; in_qk = qk;
        in_A = a; in_pc = pc; in_rob = rob;
    endtask

    typedef struct {
        logic [5:0]  order;
        logic [31:0] vj, vk, a, pc, value, topc;
    } vec_t;

    vec_t tbl [8];
    logic [5:0] ops [8];

    initial begin
        tbl[0] = '{OP_ADD,  32'd5,          32'd7,          32'd0,          32'h200, 32'd12,         32'h204};
        tbl[1] = '{OP_SUB,  32'd10,         32'd1,          32'd0,          32'h300, 32'd9,          32'h304};
        tbl[2] = '{OP_SLTU, 32'd1,          32'h8000_0000,  32'd0,          32'h10,  32'd1,          32'h14};
        tbl[3] = '{OP_JALR, 32'h1001,       32'd0,          32'd4,          32'h100, 32'h104,        32'h1004};
        tbl[4] = '{OP_XOR,  32'h0000_F0F0,  32'h0000_0FF0,  32'd0,          32'h20,  32'h0000_FF00,  32'h24};
        tbl[5] = '{OP_BEQ,  32'd3,          32'd3,          32'h10,         32'h40,  32'd0,          32'h50};
        tbl[6] = '{OP_LUI,  32'd0,          32'd0,          32'h1234_5000,  32'h80,  32'h1234_5000,  32'h84};
        tbl[7] = '{OP_ADDI, 32'hFFFF_FFFF,  32'd0,          32'd1,          32'h90,  32'd0,          32'h94};
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_SLTU; ops[3] = OP_XOR;
        ops[4] = OP_ADDI; ops[5] = OP_JALR; ops[6] = OP_BLT; ops[7] = OP_LUI;

        tick(); tick();
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_rob", {28'd0, out_rob}, 32'd0);
        check("reset out_value", out_value, 32'd0);
        check("reset out_topc", out_topc, 32'd0);
        check("reset full", {31'd0, full}, 32'd0);
        rst_in = 1'b0;
        tick();
        check("idle ex_order", {26'd0, ex_order}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            set_op(tbl[i].order, tbl[i].vj, tbl[i].vk, 1'b0, 4'd0, 1'b0, 4'd0,
                   tbl[i].a, tbl[i].pc, 4'(i + 1));
            tick();
            in_valid = 1'b0;
            check("tbl early", {31'd0, out_valid}, 32'd0);
            tick();
            check("tbl valid", {31'd0, out_valid}, 32'd1);
            check("tbl rob", {28'd0, out_rob}, i + 1);
            check("tbl value", out_value, tbl[i].value);
            check("tbl topc", out_topc, tbl[i].topc);
            tick();
        end

        // Operand arrives on the LSB CDB two cycles after dispatch.
        set_op(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'h400, 4'd4);
        tick();
        in_valid = 1'b0;
        tick(); check("wait q1", {31'd0, out_valid}, 32'd0);
        tick(); check("wait q2", {31'd0, out_valid}, 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_value = 32'd10;
        tick(); check("wake edge", {31'd0, out_valid}, 32'd0);
        lsb_cdb_valid = 1'b0;
        tick();
        check("wake valid", {31'd0, out_valid}, 32'd1);
        check("wake rob", {28'd0, out_rob}, 32'd4);
        check("wake value", out_value, 32'd9);
        tick();

        // Forwarding from a CDB broadcast in the dispatch cycle.
        set_op(OP_SLTU, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 32'd0, 32'h500, 4'd5);
        ext_alu_vld = 1'b1; ext_alu_rob = 4'd6; ext_alu_value = 32'h8000_0000;
        tick();
        in_valid = 1'b0; ext_alu_vld = 1'b0;
        tick();
        check("fwd valid", {31'd0, out_valid}, 32'd1);
        check("fwd value", out_value, 32'd1);
        tick();

        // Fill 15 entries all waiting on tag 9.
        for (int i = 0; i < 15; i++) begin
            set_op(OP_ADDI, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 32'(i), 32'h600, 4'(i));
            tick();
            if (i == 13) check("fill full 14", {31'd0, full}, 32'd0);
        end
        in_valid = 1'b0;
        check("fill full 15", {31'd0, full}, 32'd1);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd9; lsb_cdb_value = 32'd100;
        tick();
        lsb_cdb_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            check("drain rob", {28'd0, out_rob}, k);
            check("drain value", out_value, 32'd100 + 32'(k));
            if (k == 0) check("drain full", {31'd0, full}, 32'd0);
        end
        tick();
        check("drain done", {31'd0, out_valid}, 32'd0);

        // Flush with a simultaneous dispatch.
        for (int i = 0; i < 3; i++) begin
            set_op(OP_ADD, 32'd1, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 32'h700, 4'(i + 1));
            tick();
        end
        set_op(OP_ADD, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h710, 4'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear valid", {31'd0, out_valid}, 32'd0);
        check("clear full", {31'd0, full}, 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd5; lsb_cdb_value = 32'd1;
        tick();
        lsb_cdb_valid = 1'b0;
        tick(); check("clear empty1", {31'd0, out_valid}, 32'd0);
        tick(); check("clear empty2", {31'd0, out_valid}, 32'd0);

        // Stall holds the ready entry until rdy_in returns.
        set_op(OP_ADD, 32'd20, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h800, 4'd8);
        tick();
        in_valid = 1'b0; rdy_in = 1'b0;
        tick(); check("stall valid", {31'd0, out_valid}, 32'd0);
        tick(); check("stall valid2", {31'd0, out_valid}, 32'd0);
        rdy_in = 1'b1;
        tick();
        check("unstall valid", {31'd0, out_valid}, 32'd1);
        check("unstall value", out_value, 32'd42);
        tick();

        // Reset while results are issuing.
        set_op(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h900, 4'd10);
        tick();
        set_op(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h910, 4'd11);
        tick();
        in_valid = 1'b0;
        check("pre-rst valid", {31'd0, out_valid}, 32'd1);
        rst_in = 1'b1;
        tick();
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst rob", {28'd0, out_rob}, 32'd0);
        check("rst value", out_value, 32'd0);
        rst_in = 1'b0;
        tick();
        check("post-rst valid", {31'd0, out_valid}, 32'd0);

        for (int c = 0; c < 600; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            clear         = ($urandom_range(0, 99) == 0);
            in_valid      = ($urandom_range(0, 2) != 0) && (!m_full || $urandom_range(0, 7) == 0);
            in_order      = ops[$urandom_range(0, 7)];
            in_vj         = $urandom();
            in_vk         = $urandom();
            in_A          = $urandom_range(0, 255);
            in_pc         = {$urandom_range(0, 65535), 2'b00};
            in_qj_busy    = $urandom_range(0, 1);
            in_qk_busy    = $urandom_range(0, 1);
            in_qj         = 4'($urandom_range(0, 15));
            in_qk         = 4'($urandom_range(0, 15));
            in_rob        = 4'($urandom_range(0, 15));
            lsb_cdb_valid = $urandom_range(0, 1);
            lsb_cdb_rob   = 4'($urandom_range(0, 15));
            lsb_cdb_value = $urandom();
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; rdy_in = 1'b1; lsb_cdb_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
